// File: rtl/uart_cmd_parser.sv
// Purpose: pops bytes from the UART RX FIFO, parses "L<hh>\n" / "C\n" lines into the LED register.
// Latency: READ_LATENCY+3 cycles per byte (+echo wait); o_LED and o_Cmd_Valid/o_Error follow the LF decode edge.
// Backpressure: one pop outstanding at a time; with UART_CMD_ECHO_EN, i_TX_Busy stalls popping and echo.
module uart_cmd_parser #(
  parameter int         READ_LATENCY = 2,
  parameter logic [7:0] LED_RESET    = 8'h00
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Received,
  input  logic [7:0] i_Data,
  output logic       o_Read_FIFO,
  input  logic       i_TX_Busy,
  output logic       o_TX_Start,
  output logic [7:0] o_TX_Data,
  output logic [7:0] o_LED,
  output logic       o_Cmd_Valid,
  output logic       o_Error
);

  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;

  typedef enum logic [2:0] {
    F_IDLE,
    F_POP,
    F_WAIT,
`ifdef UART_CMD_ECHO_EN
    F_ECHO,
`endif
    F_DECODE
  } fetch_t;

  typedef enum logic [2:0] {
    P_CMD,
    P_HI,
    P_LO,
    P_LF,
    P_DISCARD
  } parse_t;

  fetch_t     fstate, fstate_nx;
  parse_t     pstate, pstate_nx;
  logic [2:0] cnt, cnt_nx;
  logic [7:0] byte_q, byte_nx;
  logic [7:0] val_q, val_nx;
  logic       clr_q, clr_nx;
  logic       read_nx, tx_start_nx, cmd_nx, err_nx;
  logic [7:0] tx_data_nx, led_nx;
  logic [4:0] hx;
  logic       tx_ok;

  // {valid, nibble} for an ASCII hex digit; bytes >= 0x80 never match
  function automatic logic [4:0] hex_dec(input logic [7:0] c);
    logic [4:0] r;
    r = 5'd0;
    if (c >= 8'h30 && c <= 8'h39)      r = {1'b1, c[3:0]};
    else if (c >= 8'h41 && c <= 8'h46) r = {1'b1, 4'(c[3:0] + 4'd9)};
    else if (c >= 8'h61 && c <= 8'h66) r = {1'b1, 4'(c[3:0] + 4'd9)};
    return r;
  endfunction

`ifdef UART_CMD_ECHO_EN
  assign tx_ok = !i_TX_Busy;
`else
  // Transmitter is not used without echo; the busy input is deliberately ignored
  logic unused_tx_busy;
  assign unused_tx_busy = i_TX_Busy;
  assign tx_ok = 1'b1;
`endif

  // State and registered outputs; reset drops any partial line and any in-flight pop
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      fstate      <= F_IDLE;
      pstate      <= P_CMD;
      cnt         <= 3'd0;
      byte_q      <= 8'h00;
      val_q       <= 8'h00;
      clr_q       <= 1'b0;
      o_Read_FIFO <= 1'b0;
      o_TX_Start  <= 1'b0;
      o_TX_Data   <= 8'h00;
      o_LED       <= LED_RESET;
      o_Cmd_Valid <= 1'b0;
      o_Error     <= 1'b0;
    end else begin
      fstate      <= fstate_nx;
      pstate      <= pstate_nx;
      cnt         <= cnt_nx;
      byte_q      <= byte_nx;
      val_q       <= val_nx;
      clr_q       <= clr_nx;
      o_Read_FIFO <= read_nx;
      o_TX_Start  <= tx_start_nx;
      o_TX_Data   <= tx_data_nx;
      o_LED       <= led_nx;
      o_Cmd_Valid <= cmd_nx;
      o_Error     <= err_nx;
    end
  end

  // Fetch sequencing: pop, wait out the FIFO read latency, capture, decode, optional echo
  always_comb begin
    fstate_nx   = fstate;
    cnt_nx      = cnt;
    byte_nx     = byte_q;
    read_nx     = 1'b0;
    tx_start_nx = 1'b0;
    tx_data_nx  = o_TX_Data;
    case (fstate)
      F_IDLE: begin
        if (i_Received && tx_ok) begin
          read_nx   = 1'b1;
          fstate_nx = F_POP;
        end
      end
      F_POP: begin
        cnt_nx    = 3'(READ_LATENCY - 1);
        fstate_nx = F_WAIT;
      end
      F_WAIT: begin
        if (cnt == 3'd0) begin
          byte_nx   = i_Data;
          fstate_nx = F_DECODE;
        end else begin
          cnt_nx = cnt - 3'd1;
        end
      end
      F_DECODE: begin
`ifdef UART_CMD_ECHO_EN
        fstate_nx = F_ECHO;
`else
        fstate_nx = F_IDLE;
`endif
      end
`ifdef UART_CMD_ECHO_EN
      F_ECHO: begin
        if (!i_TX_Busy) begin
          tx_start_nx = 1'b1;
          tx_data_nx  = byte_q;
          fstate_nx   = F_IDLE;
        end
      end
`endif
      default: fstate_nx = F_IDLE;
    endcase
  end

  // Line parser: advances once per decoded byte; CR is transparent in every state
  always_comb begin
    pstate_nx = pstate;
    val_nx    = val_q;
    clr_nx    = clr_q;
    led_nx    = o_LED;
    cmd_nx    = 1'b0;
    err_nx    = 1'b0;
    hx        = hex_dec(byte_q);
    if (fstate == F_DECODE && byte_q != CH_CR) begin
      case (pstate)
        P_CMD: begin
          if (byte_q == 8'h4C || byte_q == 8'h6C) begin
            clr_nx    = 1'b0;
            pstate_nx = P_HI;
          end else if (byte_q == 8'h43 || byte_q == 8'h63) begin
            clr_nx    = 1'b1;
            pstate_nx = P_LF;
          end else if (byte_q == CH_LF) begin
            pstate_nx = P_CMD;
          end else begin
            pstate_nx = P_DISCARD;
          end
        end
        P_HI, P_LO: begin
          if (hx[4]) begin
            if (pstate == P_HI) begin
              val_nx[7:4] = hx[3:0];
              pstate_nx   = P_LO;
            end else begin
              val_nx[3:0] = hx[3:0];
              pstate_nx   = P_LF;
            end
          end else if (byte_q == CH_LF) begin
            err_nx    = 1'b1;
            pstate_nx = P_CMD;
          end else begin
            pstate_nx = P_DISCARD;
          end
        end
        P_LF: begin
          if (byte_q == CH_LF) begin
            led_nx    = clr_q ? LED_RESET : val_q;
            cmd_nx    = 1'b1;
            pstate_nx = P_CMD;
          end else begin
            pstate_nx = P_DISCARD;
          end
        end
        P_DISCARD: begin
          if (byte_q == CH_LF) begin
            err_nx    = 1'b1;
            pstate_nx = P_CMD;
          end
        end
        default: pstate_nx = P_CMD;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Purpose: directed bench for uart_cmd_parser with a latency-accurate FIFO model and event scoreboard.
// Latency: FIFO model presents data LAT cycles after the pop edge; checks sample on the falling edge.
// Backpressure: i_TX_Busy driven from the stimulus; echo checks compiled when UART_CMD_ECHO_EN is defined.
module tb_uart_cmd_parser;

  localparam int LAT = 2;

  logic       i_Clock = 1'b0;
  logic       i_Reset = 1'b1;
  logic       i_Received = 1'b0;
  logic [7:0] i_Data = 8'hEE;
  logic       o_Read_FIFO;
  logic       i_TX_Busy = 1'b0;
  logic       o_TX_Start;
  logic [7:0] o_TX_Data;
  logic [7:0] o_LED;
  logic       o_Cmd_Valid;
  logic       o_Error;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] rxq[$];
  logic [8:0] evq[$];
  logic [7:0] txq[$];
  int         sent = 0;
  int         pops = 0;
  int         tx_starts = 0;
  logic [7:0] led_model = 8'h00;

  uart_cmd_parser #(.READ_LATENCY(LAT), .LED_RESET(8'h00)) dut (
    .i_Clock     (i_Clock),
    .i_Reset     (i_Reset),
    .i_Received  (i_Received),
    .i_Data      (i_Data),
    .o_Read_FIFO (o_Read_FIFO),
    .i_TX_Busy   (i_TX_Busy),
    .o_TX_Start  (o_TX_Start),
    .o_TX_Data   (o_TX_Data),
    .o_LED       (o_LED),
    .o_Cmd_Valid (o_Cmd_Valid),
    .o_Error     (o_Error)
  );

  always #5 i_Clock = ~i_Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // FIFO model: pop seen mid-cycle, data valid LAT cycles after the pop edge, junk until then
  logic [7:0] cur = 8'hEE;
  int         cd = 0;
  bit         act = 0;
  always @(negedge i_Clock) begin
    if (o_Read_FIFO) begin
      cur = (rxq.size() != 0) ? rxq.pop_front() : 8'hEE;
      i_Data = 8'hEE;
      if (LAT == 1) i_Data = cur;
      else begin
        cd  = LAT - 1;
        act = 1;
      end
    end else if (act) begin
      cd--;
      if (cd == 0) begin
        i_Data = cur;
        act    = 0;
      end
    end
    i_Received = (rxq.size() != 0);
  end

  // Output monitor: pop pulses, event scoreboard, pulse widths, echo stream
  logic prev_read = 0, prev_cv = 0, prev_err = 0;
  always @(negedge i_Clock) begin
    logic [9:0] exp_ev;
    if (o_Read_FIFO) chk("pop_width", {31'd0, prev_read}, 32'd0);
    if (o_Read_FIFO && !prev_read) pops++;
    if (o_Cmd_Valid) chk("cv_width", {31'd0, prev_cv}, 32'd0);
    if (o_Error) chk("err_width", {31'd0, prev_err}, 32'd0);
    if (o_Cmd_Valid || o_Error) begin
      chk("excl", {31'd0, o_Cmd_Valid & o_Error}, 32'd0);
      exp_ev = (evq.size() != 0) ? {1'b1, evq.pop_front()} : 10'h000;
      chk("event", {22'd0, 1'b1, o_Error, o_LED}, {22'd0, exp_ev});
    end
    if (o_TX_Start) begin
      tx_starts++;
`ifdef UART_CMD_ECHO_EN
      chk("echo_data", {24'd0, o_TX_Data}, {24'd0, (txq.size() != 0) ? txq.pop_front() : 8'hxx});
`endif
    end
    prev_read = o_Read_FIFO;
    prev_cv   = o_Cmd_Valid;
    prev_err  = o_Error;
  end

  task automatic send_byte(input logic [7:0] b);
    rxq.push_back(b);
    sent++;
`ifdef UART_CMD_ECHO_EN
    txq.push_back(b);
`endif
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic drain();
    int n = 0;
    while (rxq.size() != 0 && n < 3000) begin
      @(negedge i_Clock);
      n++;
    end
    repeat (14) @(negedge i_Clock);
    chk("drain", rxq.size(), 32'd0);
    chk("pops", pops, sent);
    chk("events_done", evq.size(), 32'd0);
    chk("led", {24'd0, o_LED}, {24'd0, led_model});
  endtask

  task automatic line_ok(input string s, input logic [7:0] v);
    led_model = v;
    evq.push_back({1'b0, v});
    send_str(s);
    send_byte(8'h0A);
    drain();
  endtask

  task automatic line_err(input string s);
    evq.push_back({1'b1, led_model});
    send_str(s);
    send_byte(8'h0A);
    drain();
  endtask

  initial begin
    int p0;
    // reset state
    repeat (3) @(negedge i_Clock);
    chk("rst_read", {31'd0, o_Read_FIFO}, 32'd0);
    chk("rst_txs", {31'd0, o_TX_Start}, 32'd0);
    chk("rst_txd", {24'd0, o_TX_Data}, 32'd0);
    chk("rst_led", {24'd0, o_LED}, 32'd0);
    chk("rst_cv", {31'd0, o_Cmd_Valid}, 32'd0);
    chk("rst_err", {31'd0, o_Error}, 32'd0);
    i_Reset = 1'b0;
    repeat (2) @(negedge i_Clock);

    line_ok("L3C", 8'h3C);
    // lowercase command with CR before LF, then clear
    led_model = 8'hA5;
    evq.push_back({1'b0, 8'hA5});
    send_str("la5");
    send_byte(8'h0D);
    send_byte(8'h0A);
    drain();
    line_ok("C", 8'h00);
    line_ok("L5A", 8'h5A);
    line_err("ab");
    line_ok("L01", 8'h01);
    line_err("L7");
    line_err("L12X");
    // empty line: no pulse expected
    send_byte(8'h0A);
    drain();
    line_err("C5");
    line_err("\200");
    line_ok("lFf", 8'hFF);

    // reset while waiting on the FIFO read for the second byte of "L5"
    send_str("L5");
    p0 = 0;
    while (pops != sent && p0 < 200) begin
      @(negedge i_Clock);
      p0++;
    end
    @(negedge i_Clock);
    i_Reset = 1'b1;
    @(negedge i_Clock);
    chk("mid_rst_read", {31'd0, o_Read_FIFO}, 32'd0);
    chk("mid_rst_led", {24'd0, o_LED}, 32'd0);
    chk("mid_rst_cv_err", {30'd0, o_Cmd_Valid, o_Error}, 32'd0);
    chk("mid_rst_txs", {31'd0, o_TX_Start}, 32'd0);
    txq.delete();
    led_model = 8'h00;
    @(negedge i_Clock);
    i_Reset = 1'b0;
    p0 = pops;
    repeat (10) @(negedge i_Clock);
    chk("no_repop", pops, p0);
    line_ok("L99", 8'h99);

    // transmitter busy held across a whole line
    i_TX_Busy = 1'b1;
    led_model = 8'h42;
    evq.push_back({1'b0, 8'h42});
    send_str("L42");
    send_byte(8'h0A);
`ifdef UART_CMD_ECHO_EN
    p0 = pops;
    repeat (50) @(negedge i_Clock);
    chk("busy_no_pop", pops, p0);
    i_TX_Busy = 1'b0;
    drain();
    chk("echo_done", txq.size(), 32'd0);
`else
    drain();
    i_TX_Busy = 1'b0;
    chk("no_tx_start", tx_starts, 32'd0);
    chk("no_tx_data", {24'd0, o_TX_Data}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
